// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Computes one quotient bit per clock; result_o = {remainder, quotient}.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start_i           request, held by execute until ready_o is seen
//   annul_i           abort an in-flight division (pipeline flush)
//   signed_div_i      1 = signed (two's complement), 0 = unsigned
//   opdata1_i         dividend
//   opdata2_i         divisor
//   result_o          {remainder, quotient}, valid while ready_o is high
//   ready_o           result valid
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned RES_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [WIDTH-1:0]   dividend_q, dividend_d;
    logic [WIDTH-1:0]   divisor_q,  divisor_d;
    logic [WIDTH-1:0]   rem_q,      rem_d;
    logic [WIDTH-1:0]   quot_q,     quot_d;
    logic               signed_q,   signed_d;
    logic               sign1_q,    sign1_d;
    logic               sign2_q,    sign2_d;
    logic               ready_q,    ready_d;
    logic [RES_W-1:0]   result_q,   result_d;

    // One restoring step: shift in the next dividend bit and trial-subtract
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   quot_final;
    logic [WIDTH-1:0]   rem_final;

    always_comb begin
        trial = {rem_q, dividend_q[WIDTH-1]};
        diff  = trial - {1'b0, divisor_q};
        // Quotient negative when operand signs differ; remainder follows dividend
        quot_final = (signed_q && (sign1_q ^ sign2_q)) ? (WIDTH'(0) - quot_q) : quot_q;
        rem_final  = (signed_q && sign1_q)             ? (WIDTH'(0) - rem_q)  : rem_q;
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        signed_d   = signed_q;
        sign1_d    = sign1_q;
        sign2_d    = sign2_q;
        ready_d    = ready_q;
        result_d   = result_q;

        unique case (state_q)
            S_IDLE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d    = S_ON;
                        cnt_d      = '0;
                        rem_d      = '0;
                        quot_d     = '0;
                        signed_d   = signed_div_i;
                        sign1_d    = opdata1_i[WIDTH-1];
                        sign2_d    = opdata2_i[WIDTH-1];
                        // Magnitudes; MIN stays 100..0, which is correct as unsigned
                        dividend_d = (signed_div_i && opdata1_i[WIDTH-1]) ?
                                     (WIDTH'(0) - opdata1_i) : opdata1_i;
                        divisor_d  = (signed_div_i && opdata2_i[WIDTH-1]) ?
                                     (WIDTH'(0) - opdata2_i) : opdata2_i;
                    end
                end
            end

            S_BYZERO: begin
                if (annul_i) begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else begin
                    state_d  = S_END;
                    ready_d  = 1'b1;
                    result_d = '0;
                end
            end

            S_ON: begin
                if (annul_i) begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else if (cnt_q != CNT_W'(WIDTH)) begin
                    dividend_d = {dividend_q[WIDTH-2:0], 1'b0};
                    if (!diff[WIDTH]) begin
                        rem_d  = diff[WIDTH-1:0];
                        quot_d = {quot_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d  = trial[WIDTH-1:0];
                        quot_d = {quot_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d  = S_END;
                    ready_d  = 1'b1;
                    result_d = {rem_final, quot_final};
                end
            end

            S_END: begin
                if (!start_i) begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end

            default: begin
                state_d  = S_IDLE;
                ready_d  = 1'b0;
                result_d = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            signed_q   <= 1'b0;
            sign1_q    <= 1'b0;
            sign2_q    <= 1'b0;
            ready_q    <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            signed_q   <= signed_d;
            sign1_q    <= sign1_d;
            sign2_q    <= sign2_d;
            ready_q    <= ready_d;
            result_q   <= result_d;
        end
    end

    assign ready_o  = ready_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed bench for div_unit with an expected-result queue.
module tb_div_unit;

    localparam int unsigned WIDTH = 32;

    logic               clk;
    logic               rst;
    logic               start_i;
    logic               annul_i;
    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;

    int checks;
    int errors;
    logic [2*WIDTH-1:0] exp_q[$];

    div_unit #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: divide magnitudes, then apply signs; divide-by-zero gives 0
    function automatic logic [63:0] ref_div(input logic sd, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] ua, ub, q, r;
        if (b == 32'd0) return 64'd0;
        ua = (sd && a[31]) ? (32'd0 - a) : a;
        ub = (sd && b[31]) ? (32'd0 - b) : b;
        q  = ua / ub;
        r  = ua % ub;
        if (sd && (a[31] ^ b[31])) q = 32'd0 - q;
        if (sd && a[31])           r = 32'd0 - r;
        return {r, q};
    endfunction

    // Full transaction: start, scramble operands, wait ready, check, hold, release
    task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
        int n;
        int lat_exp;
        logic got;
        logic [63:0] e;
        @(negedge clk);
        start_i      = 1'b1;
        signed_div_i = sd;
        opdata1_i    = a;
        opdata2_i    = b;
        exp_q.push_back(exp);
        lat_exp = (b == 32'd0) ? 2 : WIDTH + 2;
        n   = 0;
        got = 1'b0;
        while (n < 100 && !got) begin
            @(negedge clk);
            n++;
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = ~sd;
            if (ready_o) got = 1'b1;
        end
        check({tag, "_latency"}, 64'(n), 64'(lat_exp));
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
        if (got) check({tag, "_result"}, result_o, e);
        @(negedge clk);
        check({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
        check({tag, "_hold_result"}, result_o, e);
        start_i = 1'b0;
        @(negedge clk);
        check({tag, "_drop_ready"}, 64'(ready_o), 64'd0);
        check({tag, "_drop_result"}, result_o, 64'd0);
    endtask

    task automatic count_ready(input int cycles, output int highs);
        highs = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (ready_o) highs++;
        end
    endtask

    initial begin
        int highs;
        logic [31:0] ra, rb;
        logic        rs;
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 64'(ready_o), 64'd0);

        run_div("divu_100_7",   1'b0, 32'd100,      32'd7,        {32'd2, 32'd14});
        run_div("div_m7_2",     1'b1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_div("div_7_m2",     1'b1, 32'd7,        32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD});
        run_div("divu_byzero",  1'b0, 32'hFFFFFFFF, 32'd0,        64'd0);
        run_div("div_byzero",   1'b1, 32'h80000000, 32'd0,        64'd0);
        run_div("div_overflow", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000});
        run_div("divu_min_m1",  1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'd0});
        run_div("divu_max_1",   1'b0, 32'hFFFFFFFF, 32'd1,        {32'd0, 32'hFFFFFFFF});
        run_div("div_m100_m7",  1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14});

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom >> (i * 8);
            rs = 1'(i % 2);
            run_div($sformatf("rand%0d", i), rs, ra, rb, ref_div(rs, ra, rb));
        end

        // Annul mid-computation: no result may ever appear
        @(negedge clk);
        start_i = 1'b1; signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
        repeat (10) @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        check("annul_on_ready", 64'(ready_o), 64'd0);
        check("annul_on_result", result_o, 64'd0);
        count_ready(40, highs);
        check("annul_on_no_ready", 64'(highs), 64'd0);
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

        // Annul while in the divide-by-zero state
        @(negedge clk);
        start_i = 1'b1; opdata1_i = 32'd5; opdata2_i = 32'd0;
        @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        count_ready(3, highs);
        annul_i = 1'b0;
        check("annul_byzero_no_ready", 64'(highs), 64'd0);

        // Start together with annul in IDLE is not accepted
        @(negedge clk);
        start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
        count_ready(40, highs);
        start_i = 1'b0; annul_i = 1'b0;
        check("idle_annul_no_ready", 64'(highs), 64'd0);

        // Synchronous reset mid-division
        @(negedge clk);
        start_i = 1'b1; signed_div_i = 1'b1; opdata1_i = 32'hFFFF0000; opdata2_i = 32'd17;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", 64'(ready_o), 64'd0);
        check("rst_mid_result", result_o, 64'd0);
        start_i = 1'b0;
        rst     = 1'b0;
        count_ready(40, highs);
        check("rst_mid_no_ready", 64'(highs), 64'd0);
        run_div("after_rst", 1'b1, 32'hFFFF0000, 32'd17, ref_div(1'b1, 32'hFFFF0000, 32'd17));

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
